// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
// Provides the width function and default geometry.
package fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v)
                r++;
        return r;
    endfunction

    localparam int DEF_BITNUMBER = 10;
    localparam int DEF_LENGTH    = 8;
    localparam int DEF_CNT_W     = clog2(DEF_LENGTH) + 1;

endpackage

// File: rtl/fifo_param_if.sv
// Strobe, data and status bundle between the FIFO and its clients.
// master = producer/consumer side, slave = FIFO side.
interface fifo_param_if
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int LENGTH    = DEF_LENGTH
) ();

    localparam int CW = clog2(LENGTH) + 1;

    logic                 write;
    logic                 read;
    logic [BITNUMBER-1:0] data_in;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CW-1:0]        fifo_count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output write, read, data_in,
        input  data_out, valid_out, full, empty,
        input  almost_full, almost_empty,
        input  fifo_count, overflow, underflow
    );

    modport slave (
        input  write, read, data_in,
        output data_out, valid_out, full, empty,
        output almost_full, almost_empty,
        output fifo_count, overflow, underflow
    );

endinterface

// File: rtl/fifo_param_memoria_dp.sv
// Dual-port storage: synchronous write port, combinational read port.
// Contents are never reset.
module memoria_dp
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int LENGTH    = DEF_LENGTH,
    localparam int PW       = clog2(LENGTH)
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic [PW-1:0]        ptr_write,
    input  logic [BITNUMBER-1:0] data_in,
    input  logic [PW-1:0]        ptr_read,
    output logic [BITNUMBER-1:0] rd_data
);

    logic [BITNUMBER-1:0] mem [LENGTH];

    always_ff @(posedge clk) begin
        if (write)
            mem[ptr_write] <= data_in;
    end

    assign rd_data = mem[ptr_read];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered status flags.
// FIFO_FWFT_EN selects first-word-fall-through output.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int BITNUMBER       = DEF_BITNUMBER,
    parameter int LENGTH          = DEF_LENGTH,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic clk,
    input  logic reset,
    fifo_param_if.slave bus
);

    localparam int PW = clog2(LENGTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(LENGTH);
    localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 af_q;
    logic                 ae_q;
    logic                 ovf_q;
    logic                 udf_q;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [BITNUMBER-1:0] rd_data;

    // A write into a full FIFO is accepted only when a read frees a slot.
    always_comb begin
        rd_acc    = bus.read && !empty_q;
        wr_acc    = bus.write && (!full_q || rd_acc);
        count_nxt = count_q;
        if (wr_acc && !rd_acc)
            count_nxt = count_q + CW'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_MAX);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_TH);
            ae_q    <= (count_nxt <= AE_TH);
            ovf_q   <= bus.write && !wr_acc;
            udf_q   <= bus.read && !rd_acc;
        end
    end

    memoria_dp #(
        .BITNUMBER (BITNUMBER),
        .LENGTH    (LENGTH)
    ) u_mem (
        .clk       (clk),
        .write     (wr_acc),
        .ptr_write (wr_ptr),
        .data_in   (bus.data_in),
        .ptr_read  (rd_ptr),
        .rd_data   (rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = rd_data;
    assign bus.valid_out = !empty_q;
`else
    logic [BITNUMBER-1:0] dout_q;
    logic                 vout_q;

    // Read port sees the pre-edge word, so a full-FIFO
    // read+write on one address returns the old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            vout_q <= 1'b0;
        end else begin
            if (rd_acc)
                dout_q <= rd_data;
            vout_q <= rd_acc;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.valid_out = vout_q;
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Testbench for fifo_param (default build, registered read).
// Vector table, corner sequences and a queue-model random run.
module tb_fifo_param;

    localparam int BW  = 10;
    localparam int LEN = 8;
    localparam int AFT = 6;
    localparam int AET = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit wr;
        bit rd;
        int din;
        int cnt;
        int vo;
        int dout;
        int ovf;
        int udf;
    } vec_t;

    vec_t tbl[$];

    fifo_param_if #(.BITNUMBER(BW), .LENGTH(LEN)) bus ();

    fifo_param #(
        .BITNUMBER       (BW),
        .LENGTH          (LEN),
        .ALMOST_FULL_TH  (AFT),
        .ALMOST_EMPTY_TH (AET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Flags follow directly from the occupancy rules.
    task automatic chk_all(input string tag, input int cnt,
                           input int vo, input int dout,
                           input int ovf, input int udf);
        chk({tag, " count"}, int'(bus.fifo_count), cnt);
        chk({tag, " full"}, int'(bus.full), int'(cnt == LEN));
        chk({tag, " empty"}, int'(bus.empty), int'(cnt == 0));
        chk({tag, " afull"}, int'(bus.almost_full), int'(cnt >= AFT));
        chk({tag, " aempty"}, int'(bus.almost_empty),
            int'(cnt <= AET));
        chk({tag, " valid"}, int'(bus.valid_out), vo);
        chk({tag, " dout"}, int'(bus.data_out), dout);
        chk({tag, " ovf"}, int'(bus.overflow), ovf);
        chk({tag, " udf"}, int'(bus.underflow), udf);
    endtask

    task automatic step(input bit wr, input bit rd, input int din);
        bus.write   = wr;
        bus.read    = rd;
        bus.data_in = BW'(din);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(bit wr, bit rd, int din, int cnt,
                                int vo, int dout, int ovf, int udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.vo = vo; v.dout = dout; v.ovf = ovf; v.udf = udf;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    int q[$];
    int last;
    int exp_vo, exp_ovf, exp_udf;
    bit wr, rd, racc, wacc;
    int din;

    initial begin
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = '0;

        for (int i = 1; i <= 8; i++)
            add(1, 0, i, i, 0, 0, 0, 0);
        add(1, 0, 9, 8, 0, 0, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 1, 9, 8, 1, k, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 8 - k, 1, 9, 0, 0);
        add(0, 1, 0, 0, 0, 9, 0, 1);
        add(1, 1, 5, 1, 0, 9, 0, 1);
        add(0, 1, 0, 0, 1, 5, 0, 0);

        #3;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vo,
                    tbl[i].dout, tbl[i].ovf, tbl[i].udf);
        end

        // Asynchronous reset between edges with four words held.
        for (int i = 0; i < 4; i++)
            step(1, 0, 10 + i);
        step(1, 1, 20);
        chk_all("pre_rst", 4, 1, 10, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        step(1, 0, 7);
        chk_all("post_wr", 1, 0, 0, 0, 0);
        step(0, 1, 0);
        chk_all("post_rd", 0, 1, 7, 0, 0);

        // Random traffic against a queue model.
        do_reset();
        q.delete();
        last = 0;
        for (int n = 0; n < 2000; n++) begin
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 50);
            din = int'($urandom_range(0, 1023));
            racc = rd && (q.size() > 0);
            wacc = wr && ((q.size() < LEN) || racc);
            exp_vo  = int'(racc);
            exp_ovf = int'(wr && !wacc);
            exp_udf = int'(rd && !racc);
            if (racc)
                last = q.pop_front();
            if (wacc)
                q.push_back(din);
            step(wr, rd, din);
            chk_all($sformatf("rnd%0d", n), q.size(), exp_vo, last,
                    exp_ovf, exp_udf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the pointer-driven dual-port memory.
- Read and write pointers are internal, so producers and consumers drive only write/read strobes.
- Adds occupancy count, full/empty, programmable almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Sits between the memory stage and downstream consumers; the dual-port memory is reused as its storage.

Parameters:
BITNUMBER, 10, data word width in bits
LENGTH, 8, depth in words; must be a power of 2, minimum 4
ALMOST_FULL_TH, 6, almost_full asserted when count >= this value; range 1..LENGTH
ALMOST_EMPTY_TH, 2, almost_empty asserted when count <= this value; range 0..LENGTH-1

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
write  input  1  write request for this cycle
read  input  1  read request for this cycle
data_in  input  BITNUMBER  word to write
data_out  output  BITNUMBER  word read
valid_out  output  1  data_out carries a newly read word
full  output  1  count == LENGTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_TH
almost_empty  output  1  count <= ALMOST_EMPTY_TH
fifo_count  output  log2(LENGTH)+1  current occupancy, 0..LENGTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, fifo_count=0, data_out=0, valid_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Reset mid-operation: all of the above take effect without waiting for a clock edge. Memory contents are not cleared and are treated as don't-care.
- Pointers are log2(LENGTH) bits wide and wrap from LENGTH-1 to 0 with no special case.
- Read accept: rd_acc = read && !empty.
- Write accept: wr_acc = write && (!full || rd_acc). A simultaneous read and write on a full FIFO is therefore legal, and count stays at LENGTH.
- Read on an empty FIFO is rejected even if a write occurs in the same cycle; that write is accepted and count becomes 1.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- Status flags are registered and reflect the count after the edge. No combinational path from read/write to any flag.
- Read latency is 1 cycle: on the edge where rd_acc=1, data_out <= mem[rd_ptr] and valid_out=1 for exactly one cycle.
- data_out holds its last value when no read is accepted.
- Write: mem[wr_ptr] <= data_in on wr_acc.
- A same-address read and write in the same cycle returns the old word. This can only happen when the FIFO is full with both strobes active.
- Error pulses: overflow=1 for one cycle after write && !wr_acc; underflow=1 for one cycle after read && !rd_acc. The rejected operation has no other effect.

Optional Feature:
Macro: FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out always presents mem[rd_ptr] and valid_out = !empty.
  - read pops the head; the next word or the hold value appears the cycle after the pop edge.
  - A word written into an empty FIFO is visible on data_out the cycle after its write edge.
  - Accept rules, count, flags and error pulses are unchanged.
- Undefined: registered 1-cycle read latency as described above.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function for pointer and count widths.
  - Default BITNUMBER/LENGTH constants.
  - Localparam for the count width (log2(LENGTH)+1).
- Sub-module memoria_dp: dual-port storage with ports clk, write, ptr_write, data_in, ptr_read, rd_data.
  - Write is synchronous; the read port is combinational.
  - fifo_param registers the read output (or passes it straight through under FIFO_FWFT_EN).
- Pointer, count and flag logic stay in fifo_param.

Test Plan:
- Reset then idle 2 cycles -> empty=1, almost_empty=1, fifo_count=0, data_out=0, valid_out=0, overflow=0, underflow=0.
- Write 1..8 on consecutive cycles -> count steps 1..8; almost_empty drops after the 3rd write; almost_full rises after the 6th; full=1 after the 8th. A 9th write of value 9 -> overflow pulse, count stays 8.
- Full FIFO, read+write (data_in=9) for 8 cycles -> valid_out each cycle with 1..8 in order, count stays 8, no overflow. The pointer wrap is exercised.
- Drain 8 reads -> data_out 9,9,... matching writes, count reaches 0, empty=1. A further read -> underflow pulse, valid_out=0, data_out held.
- Empty FIFO, simultaneous read+write of 5 -> underflow pulse, count=1. Next-cycle read -> data_out=5, valid_out=1.
- Assert reset asynchronously between edges with count=4 -> all outputs reach reset values before the next clk edge. A subsequent write of 7 then read returns 7.
